seq_mult_arbiter: RTL and testbench

//  Shares one iterative signed multiplier between two requesters. Round-robin

---
 rtl/seq_mult_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_seq_mult_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_arbiter.sv
// seq_mult_arbiter: one iterative signed multiplier shared by two requesters.
// A round-robin arbiter picks the requester. The datapath multiplies the
// operand magnitudes with a radix-2 shift-add, one multiplier bit per cycle.
// It then applies the sign and flags products that overflow N-bit signed.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a request; ready offered to the granted side
// S_RUN  | shift-add iterations, count 0 .. N-1
// S_DONE | result presented, held until the consumer takes it
module seq_mult_arbiter #(
  parameter int N = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_req0_valid,
  output logic           o_req0_ready,
  input  logic [N-1:0]   i_req0_a,
  input  logic [N-1:0]   i_req0_b,
  input  logic           i_req1_valid,
  output logic           o_req1_ready,
  input  logic [N-1:0]   i_req1_a,
  input  logic [N-1:0]   i_req1_b,
  output logic           o_res_valid,
  input  logic           i_res_ready,
  output logic           o_res_id,
  output logic [2*N-1:0] o_res_prod,
  output logic           o_res_ovf,
  output logic           o_busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_ptr;
  logic [N-1:0]   r_mag_a;
  logic [N-1:0]   r_mag_b;
  logic           r_sign;
  logic           r_op_id;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_prod;
  logic           r_res_id;
  logic           r_ovf;

  logic           w_grant_vld;
  logic           w_grant_id;
  logic           w_accept;
  logic           w_res_hs;
  logic           w_last;
  logic [N-1:0]   w_sel_a;
  logic [N-1:0]   w_sel_b;
  logic [2*N-1:0] w_addend;
  logic [2*N-1:0] w_acc_nxt;
  logic [2*N-1:0] w_prod_nxt;
  logic           w_ovf_nxt;

  // Two's-complement magnitude. -2^(N-1) maps to 2^(N-1), which still fits
  // in N unsigned bits.
  function automatic logic [N-1:0] f_abs(input logic [N-1:0] x);
    f_abs = x[N-1] ? (~x + N'(1)) : x;
  endfunction

  // Round-robin grant: the pointer side wins if valid, else the other side.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = r_ptr;
    if (r_ptr == 1'b0) begin
      if (i_req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b0;
      end else if (i_req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b1;
      end
    end else begin
      if (i_req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b1;
      end else if (i_req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b0;
      end
    end
  end

  assign w_sel_a = w_grant_id ? i_req1_a : i_req0_a;
  assign w_sel_b = w_grant_id ? i_req1_b : i_req0_b;

  assign w_last  = (r_cnt == CW'(N - 1));

  // Partial product for the current multiplier bit, accumulated at 2N bits.
  assign w_addend   = r_mag_b[r_cnt] ? ({{N{1'b0}}, r_mag_a} << r_cnt) : '0;
  assign w_acc_nxt  = r_acc + w_addend;
  assign w_prod_nxt = r_sign ? (~w_acc_nxt + (2*N)'(1)) : w_acc_nxt;

  // The product fits in N-bit signed only when bits 2N-1..N-1 are all equal.
  assign w_ovf_nxt  = ~((&w_prod_nxt[2*N-1:N-1]) | ~(|w_prod_nxt[2*N-1:N-1]));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode. Ready is combinational and IDLE-only.
  // It is also forced low while reset is asserted.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_res_hs     = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rst_n && w_grant_vld) begin
          o_req0_ready = ~w_grant_id;
          o_req1_ready = w_grant_id;
          w_accept     = 1'b1;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_res_ready) begin
          w_res_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture at the handshake, then one shift-add step per RUN cycle.
  // The result registers load on the last step only. Because of this, they
  // stay stable through DONE regardless of new requests.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_sign   <= 1'b0;
      r_op_id  <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_res_id <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_mag_a  <= f_abs(w_sel_a);
      r_mag_b  <= f_abs(w_sel_b);
      r_sign   <= w_sel_a[N-1] ^ w_sel_b[N-1];
      r_op_id  <= w_grant_id;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_prod   <= w_prod_nxt;
        r_res_id <= r_op_id;
        r_ovf    <= w_ovf_nxt;
      end
    end
  end

  // Round-robin pointer moves to the other side once a result is consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_res_hs) begin
      r_ptr <= ~r_res_id;
    end
  end

  assign o_res_valid = (r_state == S_DONE);
  assign o_res_id    = r_res_id;
  assign o_res_prod  = r_prod;
  assign o_res_ovf   = r_ovf;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Directed bench for seq_mult_arbiter (N = 32) with hand-computed expectations.
module tb_seq_mult_arbiter;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req0_ready;
  logic [N-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready;
  logic [N-1:0]   req1_a, req1_b;
  logic           res_valid, res_ready, res_id, res_ovf, busy;
  logic [2*N-1:0] res_prod;

  int cyc   = 0;
  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_arbiter #(.N(N)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_a     (req0_a),
    .i_req0_b     (req0_b),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_a     (req1_a),
    .i_req1_b     (req1_b),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_id     (res_id),
    .o_res_prod   (res_prod),
    .o_res_ovf    (res_ovf),
    .o_busy       (busy)
  );

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic side, input logic [N-1:0] a, input logic [N-1:0] b);
    if (side) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
  endtask

  // One full transaction on one side with res_ready high.
  task automatic run_op(input logic side, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [63:0] ep, input logic eo, input string tag);
    int   k;
    int   t0;
    logic rdy;
    present(side, a, b);
    #1;
    k   = 0;
    rdy = side ? req1_ready : req0_ready;
    while (!rdy && k < 200) begin
      step();
      rdy = side ? req1_ready : req0_ready;
      k++;
    end
    chk1({tag, ":grant"}, rdy, 1'b1);
    t0 = cyc;
    step();
    // Operands must have been sampled at the handshake only.
    if (side) begin
      req1_valid = 1'b0; req1_a = ~a; req1_b = ~b;
    end else begin
      req0_valid = 1'b0; req0_a = ~a; req0_b = ~b;
    end
    chk1({tag, ":busy"}, busy, 1'b1);
    k = 0;
    while (!res_valid && k < 200) begin
      step();
      k++;
    end
    chk64({tag, ":latency"}, 64'(cyc - t0), 64'd33);
    chk64({tag, ":prod"}, res_prod, ep);
    chk1({tag, ":id"}, res_id, side);
    chk1({tag, ":ovf"}, res_ovf, eo);
    step();
    chk1({tag, ":valid_drop"}, res_valid, 1'b0);
    chk1({tag, ":idle"}, busy, 1'b0);
  endtask

  initial begin
    int   k;
    int   t0;
    int   t_prev;
    logic g;

    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready  = 1'b1;
    t_prev     = 0;
    step();
    step();

    chk1("rst:res_valid", res_valid, 1'b0);
    chk1("rst:busy", busy, 1'b0);
    chk1("rst:res_id", res_id, 1'b0);
    chk64("rst:res_prod", res_prod, 64'd0);
    chk1("rst:res_ovf", res_ovf, 1'b0);
    chk1("rst:req0_ready", req0_ready, 1'b0);
    chk1("rst:req1_ready", req1_ready, 1'b0);
    rst_n = 1'b1;
    step();

    // 7 * -6 = -42
    run_op(1'b0, 32'd7, -32'sd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, "t1");

    // Both requesters loaded from reset: strict alternation, 34-cycle spacing.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    present(1'b0, 32'd3, 32'd5);
    present(1'b1, -32'sd4, 32'd9);
    #1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!(req0_ready || req1_ready) && k < 200) begin
        step();
        k++;
      end
      g = req1_ready;
      chk1("t2:grant", g, (i % 2) == 1);
      chk1("t2:one_ready", req0_ready & req1_ready, 1'b0);
      if (i > 0) chk64("t2:spacing", 64'(cyc - t_prev), 64'd34);
      t_prev = cyc;
      step();
      k = 0;
      while (!res_valid && k < 200) begin
        step();
        k++;
      end
      chk1("t2:id", res_id, (i % 2) == 1);
      chk64("t2:prod", res_prod, ((i % 2) == 1) ? 64'hFFFF_FFFF_FFFF_FFDC : 64'd15);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Most-negative operands and zero.
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, "t3a");
    run_op(1'b1, 32'h0000_0000, 32'h8000_0000, 64'h0, 1'b0, "t3b");

    // Overflow boundary on both sides of N-bit signed range.
    run_op(1'b0, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 1'b1, "t4a");
    run_op(1'b1, -32'sd65536, 32'd32768, 64'hFFFF_FFFF_8000_0000, 1'b0, "t4b");

    // Back-pressure in DONE with req1 waiting.
    res_ready = 1'b0;
    present(1'b0, -32'sd5, -32'sd9);
    #1;
    chk1("t5:req0_ready", req0_ready, 1'b1);
    t0 = cyc;
    step();
    req0_valid = 1'b0;
    present(1'b1, 32'd1000, -32'sd3);
    #1;
    chk1("t5:req1_blocked_run", req1_ready, 1'b0);
    k = 0;
    while (!res_valid && k < 200) begin
      step();
      k++;
    end
    chk64("t5:latency", 64'(cyc - t0), 64'd33);
    for (int i = 0; i < 5; i++) begin
      chk1("t5:hold_valid", res_valid, 1'b1);
      chk64("t5:hold_prod", res_prod, 64'd45);
      chk1("t5:hold_id", res_id, 1'b0);
      chk1("t5:hold_ovf", res_ovf, 1'b0);
      chk1("t5:req1_blocked", req1_ready, 1'b0);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk1("t5:req1_blocked_hs", req1_ready, 1'b0);
    step();
    chk1("t5:req1_next", req1_ready, 1'b1);
    chk1("t5:valid_drop", res_valid, 1'b0);
    run_op(1'b1, 32'd1000, -32'sd3, 64'hFFFF_FFFF_FFFF_F448, 1'b0, "t5b");

    // Reset at RUN cycle 10 discards the operation.
    present(1'b0, 32'd11, 32'd13);
    #1;
    chk1("t6:req0_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    present(1'b1, 32'd2, -32'sd1);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk1("t6:res_valid", res_valid, 1'b0);
    chk1("t6:busy", busy, 1'b0);
    chk1("t6:req0_ready", req0_ready, 1'b0);
    chk1("t6:req1_ready", req1_ready, 1'b0);
    chk64("t6:res_prod", res_prod, 64'd0);
    chk1("t6:res_id", res_id, 1'b0);
    chk1("t6:res_ovf", res_ovf, 1'b0);
    present(1'b0, -32'sd1, -32'sd1);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk1("t6:ptr_req0", req0_ready, 1'b1);
    chk1("t6:ptr_req1", req1_ready, 1'b0);
    chk1("t6:no_result", res_valid, 1'b0);
    run_op(1'b0, -32'sd1, -32'sd1, 64'd1, 1'b0, "t6a");
    run_op(1'b1, 32'd2, -32'sd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
